// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU for the 6502-style datapath.
// Binary/BCD add and subtract one nibble per cycle, and shifts/rotates one bit
// per cycle. Logic ops and PASS finish in a single cycle. Valid/ready handshake
// on both sides; the result and N/V/Z/C flags are held until the consumer takes them.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             si,
  input  logic             dec,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             n
);

  typedef enum logic [1:0] {IDLE, ARITH, SHIFT, DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;

  localparam logic [SHW-1:0] SH_MAX  = SHW'(WIDTH);
  localparam logic [SHW-1:0] NIBBLES = SHW'(WIDTH / 4);

  state_t state, state_nxt;

  // Captured request; a_q/b_q shift right a nibble per ARITH step, res_q
  // collects result nibbles from the top (ARITH) or is the shift register (SHIFT).
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             cy_q, si_q, dec_q, a_msb_q, b_msb_q;
  logic [SHW-1:0]   cnt_q;

  logic             is_arith, is_shift;
  logic [SHW-1:0]   shamt_cl;
  logic [WIDTH-1:0] quick_f;
  logic [3:0]       b_nib, nib_digit;
  logic [4:0]       nib_sum;
  logic             nib_carry, arith_v;
  logic [WIDTH-1:0] arith_res, sh_res;
  logic             sh_c;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign is_arith  = (op == OP_ADD) || (op == OP_SUB);
  assign is_shift  = (op >= OP_SHL) && (op <= OP_ROR);
  assign shamt_cl  = (shamt > SH_MAX) ? SH_MAX : shamt;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: arithmetic and non-zero shifts go multi-cycle, all else straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (is_arith)                       state_nxt = ARITH;
          else if (is_shift && (shamt != '0)) state_nxt = SHIFT;
          else                                state_nxt = DONE;
        end
      end
      ARITH:   if (cnt_q == SHW'(1)) state_nxt = DONE;
      SHIFT:   if (cnt_q == SHW'(1)) state_nxt = DONE;
      DONE:    if (out_ready)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle result for logic ops, PASS and zero-length shifts.
  always_comb begin
    case (op)
      OP_AND:  quick_f = a & b;
      OP_OR:   quick_f = a | b;
      OP_XOR:  quick_f = a ^ b;
      default: quick_f = a;
    endcase
  end

  // One nibble of add/subtract with BCD correction; the SUB digit is fixed up when the nibble borrows.
  always_comb begin
    b_nib     = (op_q == OP_SUB) ? ~b_q[3:0] : b_q[3:0];
    nib_sum   = {1'b0, a_q[3:0]} + {1'b0, b_nib} + {4'b0000, cy_q};
    nib_digit = nib_sum[3:0];
    nib_carry = nib_sum[4];
    if (dec_q) begin
      if (op_q == OP_SUB) begin
        if (!nib_sum[4]) nib_digit = nib_sum[3:0] - 4'd6;
      end else if (nib_sum > 5'd9) begin
        nib_digit = nib_sum[3:0] + 4'd6;
        nib_carry = 1'b1;
      end
    end
    arith_res = {nib_digit, res_q[WIDTH-1:4]};
    arith_v   = !dec_q && (a_msb_q == (b_msb_q ^ (op_q == OP_SUB))) && (nib_digit[3] != a_msb_q);
  end

  // One bit of shift or rotate; rotates run through the carry as a WIDTH+1 bit ring.
  always_comb begin
    case (op_q)
      OP_SHL: begin
        sh_res = {res_q[WIDTH-2:0], si_q};
        sh_c   = res_q[WIDTH-1];
      end
      OP_SHR: begin
        sh_res = {si_q, res_q[WIDTH-1:1]};
        sh_c   = res_q[0];
      end
      OP_ROL: begin
        sh_res = {res_q[WIDTH-2:0], cy_q};
        sh_c   = res_q[WIDTH-1];
      end
      default: begin
        sh_res = {cy_q, res_q[WIDTH-1:1]};
        sh_c   = res_q[0];
      end
    endcase
  end

  // Datapath: capture on acceptance, step ARITH/SHIFT, publish result and flags on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      si_q    <= 1'b0;
      dec_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cnt_q   <= '0;
      f       <= '0;
      c       <= 1'b0;
      v       <= 1'b0;
      z       <= 1'b0;
      n       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            res_q   <= a;
            cy_q    <= ci;
            si_q    <= si;
            dec_q   <= dec;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            cnt_q   <= is_arith ? NIBBLES : shamt_cl;
            if (state_nxt == DONE) begin
              f <= quick_f;
              c <= ci;
              v <= 1'b0;
              z <= (quick_f == '0);
              n <= quick_f[WIDTH-1];
            end
          end
        end
        ARITH: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          res_q <= arith_res;
          cy_q  <= nib_carry;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            f <= arith_res;
            c <= nib_carry;
            v <= arith_v;
            z <= (arith_res == '0);
            n <= arith_res[WIDTH-1];
          end
        end
        SHIFT: begin
          res_q <= sh_res;
          cy_q  <= sh_c;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            f <= sh_res;
            c <= sh_c;
            v <= 1'b0;
            z <= (sh_res == '0);
            n <= sh_res[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized scoreboard bench for alu_seq (WIDTH=8).
module tb_alu_seq;

  localparam int W   = 8;
  localparam int SHW = $clog2(W) + 1;

  typedef struct {
    logic [W-1:0] f;
    logic         c, v, z, n;
    int           lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [3:0]     op = '0;
  logic [W-1:0]   a = '0, b = '0;
  logic           ci = 1'b0, si = 1'b0, dec = 1'b0;
  logic [SHW-1:0] shamt = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   f;
  logic           c, v, z, n;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  alu_seq #(.WIDTH(W), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .ci(ci), .si(si), .dec(dec), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .c(c), .v(v), .z(z), .n(n)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] x);
    int r = 0;
    for (int i = W / 4 - 1; i >= 0; i--) r = r * 10 + int'(x[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int x);
    logic [W-1:0] r = '0;
    int t = x;
    for (int i = 0; i < W / 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference model: decimal/integer arithmetic and whole-word shifts.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                                 input logic cii, input logic sii, input logic deci, input logic [SHW-1:0] sh);
    exp_t e;
    int k, s, p, sa, sb_, lim;
    logic [2*W:0] t;
    logic [W:0] r;
    e.f = ai; e.c = cii; e.v = 1'b0; e.lat = 1;
    k = (int'(sh) > W) ? W : int'(sh);
    case (o)
      4'd0, 4'd1: begin
        e.lat = W / 4 + 1;
        if (deci) begin
          p = 10 ** (W / 4);
          if (o == 4'd0) begin
            s = bcd2int(ai) + bcd2int(bi) + int'(cii);
            e.c = (s >= p);
            s = s % p;
          end else begin
            s = bcd2int(ai) - bcd2int(bi) - (1 - int'(cii));
            e.c = (s >= 0);
            if (s < 0) s = s + p;
          end
          e.f = int2bcd(s);
        end else begin
          if (o == 4'd0) s = int'(ai) + int'(bi) + int'(cii);
          else           s = int'(ai) + (2 ** W - 1 - int'(bi)) + int'(cii);
          e.f = W'(s);
          e.c = (s >= 2 ** W);
          sa  = int'($signed(ai));
          sb_ = int'($signed(bi));
          if (o == 4'd0) s = sa + sb_ + int'(cii);
          else           s = sa - sb_ - (1 - int'(cii));
          lim = 2 ** (W - 1);
          e.v = (s > lim - 1) || (s < -lim);
        end
      end
      4'd2: e.f = ai & bi;
      4'd3: e.f = ai | bi;
      4'd4: e.f = ai ^ bi;
      4'd5, 4'd6, 4'd7, 4'd8: begin
        if (k > 0) begin
          e.lat = k + 1;
          case (o)
            4'd5: begin
              t = {1'b0, ai, {W{sii}}};
              t = t << k;
              e.f = t[2*W-1:W];
              e.c = t[2*W];
            end
            4'd6: begin
              t = {{W{sii}}, ai, 1'b0};
              t = t >> k;
              e.f = t[W:1];
              e.c = t[0];
            end
            4'd7: begin
              r = {cii, ai};
              repeat (k) r = {r[W-1:0], r[W]};
              e.f = r[W-1:0];
              e.c = r[W];
            end
            default: begin
              r = {cii, ai};
              repeat (k) r = {r[0], r[W:1]};
              e.f = r[W-1:0];
              e.c = r[W];
            end
          endcase
        end
      end
      default: e.f = ai;
    endcase
    e.z = (e.f == '0);
    e.n = e.f[W-1];
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] ff, input logic cc, input logic vv,
                              input logic zz, input logic nn, input int lat);
    exp_t e;
    e.f = ff; e.c = cc; e.v = vv; e.z = zz; e.n = nn; e.lat = lat;
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever a result handshake is about to happen.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got f=%0h with no expected entry", f);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("res_f", 32'(f), 32'(e.f));
        checkOutput("res_c", 32'(c), 32'(e.c));
        checkOutput("res_v", 32'(v), 32'(e.v));
        checkOutput("res_z", 32'(z), 32'(e.z));
        checkOutput("res_n", 32'(n), 32'(e.n));
      end
    end
  end

  task automatic scramble();
    op    = 4'($urandom);
    a     = W'($urandom);
    b     = W'($urandom);
    ci    = 1'($urandom);
    si    = 1'($urandom);
    dec   = 1'($urandom);
    shamt = SHW'($urandom);
  endtask

  // Issue one op (caller sits just after a rising edge), check latency, stall, then handshake.
  task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                               input logic cii, input logic sii, input logic deci,
                               input logic [SHW-1:0] sh, input exp_t e, input int stall);
    int guard = 0;
    int lat;
    op = o; a = ai; b = bi; ci = cii; si = sii; dec = deci; shamt = sh;
    in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(e.lat));
    out_ready = (stall == 0);
    if (stall > 0) in_valid = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_f", 32'(f), 32'(e.f));
      checkOutput("stall_c", 32'(c), 32'(e.c));
      scramble();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("post_hs_out_valid", 32'(out_valid), 32'd0);
    checkOutput("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic runRandom(input int count);
    logic [3:0] o;
    logic [W-1:0] ai, bi;
    logic cii, sii, deci;
    logic [SHW-1:0] sh;
    for (int i = 0; i < count; i++) begin
      o    = 4'($urandom_range(0, 15));
      ai   = W'($urandom);
      bi   = W'($urandom);
      cii  = 1'($urandom);
      sii  = 1'($urandom);
      deci = 1'($urandom);
      sh   = SHW'($urandom);
      if (deci && (o <= 4'd1)) begin
        for (int d = 0; d < W / 4; d++) begin
          ai[4*d +: 4] = 4'($urandom_range(0, 9));
          bi[4*d +: 4] = 4'($urandom_range(0, 9));
        end
      end
      applyStimulus(o, ai, bi, cii, sii, deci, sh, model(o, ai, bi, cii, sii, deci, sh),
                    $urandom_range(0, 2));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_f", 32'(f), 32'd0);
    checkOutput("rst_c", 32'(c), 32'd0);
    checkOutput("rst_v", 32'(v), 32'd0);
    checkOutput("rst_z", 32'(z), 32'd0);
    checkOutput("rst_n", 32'(n), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors with hand-derived results.
    applyStimulus(4'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0, mk(8'h80, 0, 1, 0, 1, 3), 0);
    applyStimulus(4'd1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 4'd0, mk(8'hFF, 0, 0, 0, 1, 3), 0);
    applyStimulus(4'd0, 8'h58, 8'h46, 1'b1, 1'b0, 1'b1, 4'd0, mk(8'h05, 1, 0, 0, 0, 3), 0);
    applyStimulus(4'd1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 4'd0, mk(8'h99, 0, 0, 0, 1, 3), 0);
    applyStimulus(4'd5, 8'h81, 8'h00, 1'b0, 1'b1, 1'b0, 4'd3, mk(8'h0F, 0, 0, 0, 0, 4), 0);
    applyStimulus(4'd8, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1, mk(8'h00, 1, 0, 1, 0, 2), 0);
    applyStimulus(4'd2, 8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0, 4'd0, mk(8'h30, 1, 0, 0, 0, 1), 0);
    applyStimulus(4'd6, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 4'd12, mk(8'h00, 1, 0, 1, 0, 9), 0);
    applyStimulus(4'd7, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, mk(8'h80, 1, 0, 0, 1, 1), 0);
    applyStimulus(4'd12, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0, 4'd5, mk(8'h00, 0, 0, 1, 0, 1), 0);
    applyStimulus(4'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0, mk(8'h80, 0, 1, 0, 1, 3), 5);

    // Reset in the middle of an ADD: nothing is reported and the next op runs cleanly.
    op = 4'd0; a = 8'h12; b = 8'h34; ci = 1'b0; dec = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_f", 32'(f), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_quiet", 32'(out_valid), 32'd0);
    applyStimulus(4'd0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 4'd0, mk(8'h46, 0, 0, 0, 0, 3), 1);

    runRandom(200);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
